// File: rtl/audio_i2s_rx.sv
// rtl/audio_i2s_rx.sv - I2S capture front-end producing stereo frame words
module audio_i2s_rx #(
  parameter int SAMPLE_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i2s_bclk,
  input  logic        i2s_lrclk,
  input  logic        i2s_sdata,
  input  logic        enable,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        ovf,
  output logic        short_err,
  input  logic        err_clr,
  output logic [15:0] frame_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SYNC  = 2'd1;
  localparam logic [1:0] ST_LEFT  = 2'd2;
  localparam logic [1:0] ST_RIGHT = 2'd3;

  localparam logic [5:0] SW      = 6'(SAMPLE_W);
  localparam logic [5:0] SW_LAST = 6'(SAMPLE_W - 1);

  logic                bclk_s1, bclk_s2, bclk_s3;
  logic                lr_s1, lr_s2, lr_prev;
  logic                sd_s1, sd_s2;
  logic                bclk_rise, right_start, left_start, data_bit, cap_en;
  logic [5:0]          bit_cnt;
  logic [1:0]          state;
  logic [SAMPLE_W-1:0] left_sh, right_sh;
  logic                got_frame, done, short_set, accept;
  logic [15:0]         left_half, right_half;

  // Two-flop synchronizers on all pins, plus a third BCLK flop for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bclk_s1 <= 1'b0; bclk_s2 <= 1'b0; bclk_s3 <= 1'b0;
      lr_s1   <= 1'b0; lr_s2   <= 1'b0; lr_prev <= 1'b0;
      sd_s1   <= 1'b0; sd_s2   <= 1'b0;
    end else begin
      bclk_s1 <= i2s_bclk;  bclk_s2 <= bclk_s1; bclk_s3 <= bclk_s2;
      lr_s1   <= i2s_lrclk; lr_s2   <= lr_s1;
      sd_s1   <= i2s_sdata; sd_s2   <= sd_s1;
      if (bclk_rise) lr_prev <= lr_s2;
    end
  end

  assign bclk_rise   = bclk_s2 & ~bclk_s3;
  assign right_start = bclk_rise & lr_s2 & ~lr_prev;
  assign left_start  = bclk_rise & ~lr_s2 & lr_prev;
  // The bit on the edge that reveals an LRCLK change belongs to the old slot
  assign data_bit    = bclk_rise & ~(right_start | left_start);
  assign cap_en      = data_bit & (bit_cnt < SW);

  // Per-slot bit counter, saturating so long slots never wrap back into range
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt <= 6'd0;
    end else if (right_start || left_start) begin
      bit_cnt <= 6'd0;
    end else if (bclk_rise && bit_cnt != 6'd63) begin
      bit_cnt <= bit_cnt + 6'd1;
    end
  end

  assign short_set = enable &
                     (((state == ST_LEFT)  & right_start & (bit_cnt < SW)) |
                      ((state == ST_RIGHT) & left_start  & ~got_frame));

  // Frame alignment FSM and channel shift registers; done pulses on the last right bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      left_sh   <= '0;
      right_sh  <= '0;
      got_frame <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!enable) begin
        state     <= ST_IDLE;
        got_frame <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_SYNC;
          ST_SYNC: if (left_start) state <= ST_LEFT;
          ST_LEFT: begin
            if (cap_en) left_sh <= {left_sh[SAMPLE_W-2:0], sd_s2};
            if (right_start) begin
              state     <= (bit_cnt >= SW) ? ST_RIGHT : ST_SYNC;
              got_frame <= 1'b0;
            end
          end
          ST_RIGHT: begin
            if (cap_en) begin
              right_sh <= {right_sh[SAMPLE_W-2:0], sd_s2};
              if (bit_cnt == SW_LAST) begin
                got_frame <= 1'b1;
                done      <= 1'b1;
              end
            end
            if (left_start) begin
              state     <= ST_LEFT;
              got_frame <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Left-justify each channel into 16 bits: truncate wide samples, zero-pad narrow ones
  if (SAMPLE_W >= 16) begin : g_wide
    assign left_half  = left_sh[SAMPLE_W-1 -: 16];
    assign right_half = right_sh[SAMPLE_W-1 -: 16];
  end else begin : g_narrow
    assign left_half  = {left_sh,  {(16-SAMPLE_W){1'b0}}};
    assign right_half = {right_sh, {(16-SAMPLE_W){1'b0}}};
  end

  assign accept = out_valid & out_ready;

  // Output register, delivery counter and sticky error flags (set beats clear)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= 32'd0;
      out_valid <= 1'b0;
      frame_cnt <= 16'd0;
      ovf       <= 1'b0;
      short_err <= 1'b0;
    end else begin
      if (done && (!out_valid || out_ready)) begin
        out_data  <= {left_half, right_half};
        out_valid <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      if (accept) frame_cnt <= frame_cnt + 16'd1;
      if (done && out_valid && !out_ready) ovf <= 1'b1;
      else if (err_clr)                    ovf <= 1'b0;
      if (short_set)    short_err <= 1'b1;
      else if (err_clr) short_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_i2s_rx.sv
// tb/tb_audio_i2s_rx.sv - directed bench for audio_i2s_rx
module tb_audio_i2s_rx;

  logic        clk = 1'b0;
  logic        rst_n, bclk, lrclk, sdata, enable, out_ready, err_clr;
  logic [31:0] out_data;
  logic        out_valid, ovf, short_err;
  logic [15:0] frame_cnt;

  int          n_checks = 0;
  int          n_errs   = 0;
  logic        ov_a, ov_b, ov_c;
  logic [31:0] cap;
  logic [15:0] pat_l, pat_r;

  audio_i2s_rx #(.SAMPLE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sdata(sdata),
    .enable(enable), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ovf(ovf), .short_err(short_err), .err_clr(err_clr), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One BCLK period: data/LRCLK change with BCLK low, 3 clk low then 3 clk high
  task automatic bit_out(input logic lr, input logic d);
    bclk = 1'b0; lrclk = lr; sdata = d;
    nclk(3);
    bclk = 1'b1;
    nclk(3);
  endtask

  // Slot bit 0 is the discarded delay bit, bits 1..16 carry the sample, the rest are filler ones
  function automatic logic slot_bit(input logic [15:0] s, input int idx);
    if (idx >= 1 && idx <= 16) return s[16-idx];
    return 1'b1;
  endfunction

  task automatic send_bits(input logic lr, input logic [15:0] s, input int lo, input int hi);
    for (int i = lo; i < hi; i++) bit_out(lr, slot_bit(s, i));
  endtask

  // Full frame; around the last right bit samples out_valid 3, 4 and 5 clk edges after the pin edge
  task automatic frame(input logic [15:0] l, input logic [15:0] r, input int lbits = 32,
                       input logic clr = 1'b0);
    send_bits(1'b0, l, 0, lbits);
    send_bits(1'b1, r, 0, 16);
    bclk = 1'b0; lrclk = 1'b1; sdata = r[0];
    nclk(3);
    bclk = 1'b1;
    nclk(3);
    ov_a = out_valid;
    if (clr) err_clr = 1'b1;
    nclk(1);
    ov_b = out_valid;
    cap  = out_data;
    err_clr = 1'b0;
    nclk(1);
    ov_c = out_valid;
    send_bits(1'b1, r, 17, 32);
  endtask

  initial begin
    rst_n = 1'b0; bclk = 1'b1; lrclk = 1'b1; sdata = 1'b0;
    enable = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    nclk(3);
    rst_n = 1'b1;
    nclk(1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_ovf",       ovf,       0);
    check("rst_short_err", short_err, 0);
    check("rst_frame_cnt", frame_cnt, 0);

    // Nominal capture and exact output latency
    enable = 1'b1;
    send_bits(1'b1, 16'h0000, 0, 32);
    frame(16'h1234, 16'hABCD);
    check("nom_lat_edge3", ov_a, 0);
    check("nom_lat_edge4", ov_b, 1);
    check("nom_pulse_end", ov_c, 0);
    check("nom_data",      cap,  32'h1234ABCD);
    check("nom_cnt1",      frame_cnt, 1);
    for (int i = 1; i < 8; i++) begin
      pat_l = 16'(i * 16'h1357);
      pat_r = ~pat_l;
      frame(pat_l, pat_r);
      check("nom_loop_data", cap, {pat_l, pat_r});
    end
    check("nom_cnt8",  frame_cnt, 8);
    check("nom_short", short_err, 0);

    // Enable raised in the middle of a right slot
    enable = 1'b0;
    send_bits(1'b0, 16'hDEAD, 0, 32);
    send_bits(1'b1, 16'hBEEF, 0, 8);
    enable = 1'b1;
    send_bits(1'b1, 16'hBEEF, 8, 32);
    frame(16'h0F0F, 16'hF0F0);
    check("en_mid_valid", ov_b, 1);
    check("en_mid_data",  cap,  32'h0F0FF0F0);
    check("en_mid_cnt",   frame_cnt, 9);
    check("en_mid_short", short_err, 0);

    // Backpressure: first word held, later frames dropped
    out_ready = 1'b0;
    frame(16'h0001, 16'h0002);
    check("bp_first_data", cap, 32'h00010002);
    check("bp_first_ovf",  ovf, 0);
    frame(16'h0003, 16'h0004);
    frame(16'h0005, 16'h0006);
    check("bp_hold_data",  out_data,  32'h00010002);
    check("bp_hold_valid", out_valid, 1);
    check("bp_ovf",        ovf,       1);
    check("bp_cnt_held",   frame_cnt, 9);
    out_ready = 1'b1;
    nclk(1);
    check("bp_drain_valid", out_valid, 0);
    check("bp_drain_cnt",   frame_cnt, 10);
    nclk(5);
    check("bp_one_xfer", frame_cnt, 10);
    err_clr = 1'b1;
    nclk(1);
    err_clr = 1'b0;
    check("bp_ovf_clr", ovf, 0);

    // Short left slot, then a good frame
    send_bits(1'b0, 16'h1111, 0, 10);
    send_bits(1'b1, 16'h2222, 0, 32);
    check("sl_short_err", short_err, 1);
    check("sl_no_frame",  out_valid, 0);
    check("sl_cnt",       frame_cnt, 10);
    frame(16'h5555, 16'hAAAA);
    check("sl_good_data", cap, 32'h5555AAAA);
    check("sl_good_cnt",  frame_cnt, 11);
    err_clr = 1'b1;
    nclk(1);
    err_clr = 1'b0;
    check("sl_clr", short_err, 0);

    // Short right slot drops the frame; the next frame is intact
    send_bits(1'b0, 16'h7777, 0, 32);
    send_bits(1'b1, 16'h8888, 0, 10);
    frame(16'h1357, 16'h2468);
    check("sr_short_err", short_err, 1);
    check("sr_good_data", cap, 32'h13572468);
    check("sr_cnt",       frame_cnt, 12);
    err_clr = 1'b1;
    nclk(1);
    err_clr = 1'b0;

    // Left slot with exactly one delay bit plus 16 data bits is not short
    frame(16'h0A0B, 16'h0C0D, 17);
    check("bnd_data",  cap, 32'h0A0B0C0D);
    check("bnd_short", short_err, 0);
    check("bnd_cnt",   frame_cnt, 13);

    // Reset during a right slot with a pending word
    out_ready = 1'b0;
    frame(16'h4444, 16'h8888);
    check("rm_pending", out_valid, 1);
    send_bits(1'b0, 16'h0001, 0, 32);
    send_bits(1'b1, 16'h0002, 0, 8);
    rst_n = 1'b0;
    nclk(1);
    rst_n = 1'b1;
    check("rm_valid", out_valid, 0);
    check("rm_data",  out_data,  0);
    check("rm_cnt",   frame_cnt, 0);
    check("rm_ovf",   ovf,       0);
    check("rm_short", short_err, 0);
    out_ready = 1'b1;
    send_bits(1'b1, 16'h0002, 8, 32);
    check("rm_no_partial", frame_cnt, 0);
    frame(16'h6666, 16'h9999);
    check("rm_next_data", cap, 32'h66669999);
    check("rm_next_cnt",  frame_cnt, 1);

    // Counter wrap from a preloaded 0xFFFF
    out_ready = 1'b0;
    frame(16'h0102, 16'h0304);
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    nclk(1);
    out_ready = 1'b1;
    nclk(1);
    out_ready = 1'b0;
    check("wrap_cnt",   frame_cnt, 0);
    check("wrap_valid", out_valid, 0);

    // Clear in the same cycle as a new overflow loses to the set
    frame(16'h1111, 16'h2222);
    check("pri_load", cap, 32'h11112222);
    check("pri_ovf0", ovf, 0);
    frame(16'h3333, 16'h4444, 32, 1'b1);
    check("pri_ovf_kept", ovf, 1);
    check("pri_hold",     cap, 32'h11112222);
    err_clr = 1'b1;
    nclk(1);
    err_clr = 1'b0;
    check("pri_clr_later", ovf, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
